cam_tx: RTL and testbench
=========================

CAM_TX -- requirements
Module: cam_tx

Interface
REQ-001 Parameter H_ACTIVE, default 640: active pixels per line.
REQ-002 Parameter V_ACTIVE, default 480: active lines per frame.
REQ-003 Parameter H_BLANK, default 144: href-low cycles after each active line, minimum 2.
REQ-004 Parameter VSYNC_CYC, default 4704: vsync-high cycles per frame, minimum 4.
REQ-005 Parameter VBP_CYC, default 16464: cycles from vsync falling to the first href, minimum 4.
REQ-006 Parameter VFP_CYC, default 14112: cycles from the end of the last line's blank to the next vsync rise, minimum 1.
REQ-007 Clock and reset: one clock; reset is synchronous and active-high. Ports are pclk and rst.
REQ-008 pclk, input, 1: sole clock; all outputs are registered on its rising edge.
REQ-009 rst, input, 1: synchronous active-high reset.
REQ-010 en, input, 1: level; while high, frames are transmitted back-to-back.
REQ-011 rd_addr, output, 19: frame-buffer pixel address.
REQ-012 rd_en, output, 1: frame-buffer read strobe.
REQ-013 rd_data, input, 12: RGB444 pixel {R[3:0],G[3:0],B[3:0]}, valid the cycle after rd_en.
REQ-014 vsync, output, 1: high during the frame sync interval.
REQ-015 href, output, 1: high while D carries active pixel bytes.
REQ-016 D, output, 8: DVP data byte.
REQ-017 frame_done, output, 1: one-cycle pulse on the cycle vsync rises for the next frame, or on entry to IDLE.
REQ-018 busy, output, 1: high in every state except IDLE.

Function
REQ-019 FSM states and transitions:
- IDLE -> VSYNC when en=1.
- VSYNC (VSYNC_CYC cycles) -> VBP (VBP_CYC cycles) -> ACTIVE.
- ACTIVE (2*H_ACTIVE cycles) -> HBLANK (H_BLANK cycles).
- HBLANK -> ACTIVE if lines remain; otherwise -> VFP (VFP_CYC cycles).
- VFP -> VSYNC if en=1; otherwise -> IDLE.
REQ-020 vsync is high exactly during VSYNC; href is high exactly during ACTIVE.
REQ-021 Each pixel occupies two consecutive ACTIVE cycles:
- byte0 = {4'h0, R[3:0]};
- byte1 = {G[3:0], B[3:0]}.
REQ-022 D is 8'h00 whenever href is low.
REQ-023 rd_en pulses once per pixel; byte0 of a pixel appears on D exactly 2 cycles after the cycle in which rd_en=1 and rd_addr holds that pixel's address.
REQ-024 The first rd_en of each line occurs during the last 2 cycles of VBP or HBLANK, with no gap at the line start.
REQ-025 Pixel data is held in an internal register so that byte1 uses the same rd_data sample as byte0.
REQ-026 Addressing:
- rd_addr is 0 for the first pixel of each frame and increments by 1 per pixel;
- the last pixel is at H_ACTIVE*V_ACTIVE-1;
- rd_addr is reset to 0 in VSYNC;
- rd_addr never exceeds H_ACTIVE*V_ACTIVE-1.
REQ-027 Counter widths: column counter 12 bits; line counter 10 bits; interval counter 16 bits. All counters compare to parameter-1 and clear on state change.
REQ-028 en falling mid-frame does not truncate the frame; the transition to IDLE happens only at the end of VFP.
REQ-029 en rising in the same cycle VFP ends enters VSYNC with no IDLE cycle.
REQ-030 frame_done and a VFP->VSYNC transition coincide in one cycle; no double pulse.

Reset
REQ-031 On rst=1 at a pclk edge, the next state is IDLE and all outputs are 0: vsync, href, D, rd_en, rd_addr, frame_done, busy.
REQ-032 rst mid-frame aborts immediately with no frame_done pulse; rst has priority over en.
REQ-033 After rst falls with en=1, vsync rises on the second pclk edge.

Structure
REQ-034 Shared package cam_pkg holds:
- FSM state encoding (IDLE, VSYNC, VBP, ACTIVE, HBLANK, VFP);
- the RGB444 byte-packing constant (byte0 upper nibble 4'h0);
- PIX_ADDR_W=19 and PIX_DATA_W=12, shared with the capture side.
REQ-035 Single flat module; no sub-module is natural, since timing counters and read prefetch share state.

Verification
REQ-036 H_ACTIVE=4, V_ACTIVE=2, H_BLANK=3, VSYNC_CYC=4, VBP_CYC=5, VFP_CYC=2, en=1, memory rd_data=addr*12'h111 -> 2 lines of 8 href cycles each; D per line = 00,00,01,11,02,22,03,33 then 04,44,05,55,06,66,07,77; vsync high for 4 cycles; frame period 4+5+2*(8+3)+2 = 33 cycles.
REQ-037 Same parameters, memory model with 1-cycle latency -> rd_en count per frame = 8; rd_addr sequence 0..7; rd_addr never equals 8.
REQ-038 en dropped at cycle 10 of a frame -> frame completes, frame_done pulses once, busy falls, and vsync stays low thereafter.
REQ-039 rst asserted during the second ACTIVE line -> next cycle all outputs are 0 with no frame_done pulse; after release with en=1, a full frame restarts at rd_addr=0.
REQ-040 Loopback into the capture block with its cam_done=1, 3 frames -> the capture block writes 8 pixels per frame, with pix_addr/pix_data matching rd_addr/rd_data.

Source files
------------

// File: rtl/cam_pkg.sv
// Shared DVP camera definitions: FSM encoding, pixel widths
// and RGB444 byte packing used by transmit and capture sides.
package cam_pkg;

  localparam int PIX_ADDR_W = 19;
  localparam int PIX_DATA_W = 12;

  localparam logic [3:0] BYTE0_HI = 4'h0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_VBP,
    ST_ACTIVE,
    ST_HBLANK,
    ST_VFP
  } cam_state_t;

  function automatic logic [7:0] dvp_byte0(
    input logic [3:0] r
  );
    return {BYTE0_HI, r};
  endfunction

  function automatic logic [7:0] dvp_byte1(
    input logic [3:0] g,
    input logic [3:0] b
  );
    return {g, b};
  endfunction

endpackage

// File: rtl/cam_tx.sv
// DVP camera transmitter: streams an RGB444 frame buffer as
// vsync/href/D byte pairs with frame-buffer prefetch.
module cam_tx
  import cam_pkg::*;
#(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int H_BLANK   = 144,
  parameter int VSYNC_CYC = 4704,
  parameter int VBP_CYC   = 16464,
  parameter int VFP_CYC   = 14112
) (
  input  logic                  pclk,
  input  logic                  rst,
  input  logic                  en,
  output logic [PIX_ADDR_W-1:0] rd_addr,
  output logic                  rd_en,
  input  logic [PIX_DATA_W-1:0] rd_data,
  output logic                  vsync,
  output logic                  href,
  output logic [7:0]            D,
  output logic                  frame_done,
  output logic                  busy
);

  localparam logic [11:0] COL_LAST =
    12'(2 * H_ACTIVE - 1);
  localparam logic [11:0] COL_PRE =
    12'(2 * H_ACTIVE - 2);
  localparam logic [9:0] LINE_LAST =
    10'(V_ACTIVE - 1);
  localparam logic [15:0] VS_LAST =
    16'(VSYNC_CYC - 1);
  localparam logic [15:0] VBP_LAST =
    16'(VBP_CYC - 1);
  localparam logic [15:0] VBP_PRE =
    16'(VBP_CYC - 2);
  localparam logic [15:0] HB_LAST =
    16'(H_BLANK - 1);
  localparam logic [15:0] HB_PRE =
    16'(H_BLANK - 2);
  localparam logic [15:0] VFP_LAST =
    16'(VFP_CYC - 1);
  localparam logic [PIX_ADDR_W-1:0] ADDR_LAST =
    PIX_ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

  cam_state_t  state;
  logic [15:0] cnt;
  logic [11:0] col;
  logic [9:0]  line;
  logic [7:0]  pix;
  logic        wrap;
  logic        issue;

  // Reads run two cycles ahead of the byte0 slot of each pixel.
  always_comb begin
    issue = 1'b0;
    case (state)
      ST_VBP:
        issue = (cnt == VBP_PRE);
      ST_HBLANK:
        issue = (cnt == HB_PRE) &&
                (line != LINE_LAST);
      ST_ACTIVE:
        issue = !col[0] && (col < COL_PRE);
      default:
        issue = 1'b0;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      col        <= '0;
      line       <= '0;
      pix        <= '0;
      wrap       <= 1'b0;
      vsync      <= 1'b0;
      href       <= 1'b0;
      D          <= '0;
      rd_en      <= 1'b0;
      rd_addr    <= '0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      vsync      <= (state == ST_VSYNC);
      href       <= (state == ST_ACTIVE);
      busy       <= (state != ST_IDLE);
      rd_en      <= issue;
      frame_done <= wrap;
      wrap       <= 1'b0;
      D          <= 8'h00;

      if (state == ST_ACTIVE) begin
        if (!col[0]) begin
          D   <= dvp_byte0(rd_data[11:8]);
          pix <= rd_data[7:0];
        end else begin
          D <= dvp_byte1(pix[7:4], pix[3:0]);
        end
      end

      // Advance after each strobe; hold at the last pixel.
      if (state == ST_VSYNC)
        rd_addr <= '0;
      else if (rd_en && rd_addr != ADDR_LAST)
        rd_addr <= rd_addr + PIX_ADDR_W'(1);

      unique case (state)
        ST_IDLE: begin
          if (en)
            state <= ST_VSYNC;
        end
        ST_VSYNC: begin
          cnt <= cnt + 16'd1;
          if (cnt == VS_LAST) begin
            state <= ST_VBP;
            cnt   <= '0;
          end
        end
        ST_VBP: begin
          cnt <= cnt + 16'd1;
          if (cnt == VBP_LAST) begin
            state <= ST_ACTIVE;
            cnt   <= '0;
            col   <= '0;
            line  <= '0;
          end
        end
        ST_ACTIVE: begin
          col <= col + 12'd1;
          if (col == COL_LAST) begin
            state <= ST_HBLANK;
            col   <= '0;
            cnt   <= '0;
          end
        end
        ST_HBLANK: begin
          cnt <= cnt + 16'd1;
          if (cnt == HB_LAST) begin
            cnt <= '0;
            if (line == LINE_LAST) begin
              state <= ST_VFP;
            end else begin
              state <= ST_ACTIVE;
              line  <= line + 10'd1;
              col   <= '0;
            end
          end
        end
        ST_VFP: begin
          cnt <= cnt + 16'd1;
          if (cnt == VFP_LAST) begin
            cnt   <= '0;
            wrap  <= 1'b1;
            state <= en ? ST_VSYNC : ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_tx.sv
// Bench for cam_tx: frame timing, byte stream, prefetch
// addressing, en handling and mid-frame reset.
module tb_cam_tx;

  localparam int HA    = 4;
  localparam int VA    = 2;
  localparam int HB    = 3;
  localparam int VS    = 4;
  localparam int VBP   = 5;
  localparam int VFP   = 2;
  localparam int LINE  = 2 * HA + HB;
  localparam int FRAME = VS + VBP + VA * LINE + VFP;
  localparam int NPIX  = HA * VA;

  logic        pclk = 1'b0;
  logic        rst  = 1'b1;
  logic        en   = 1'b0;
  logic [18:0] rd_addr;
  logic        rd_en;
  logic [11:0] rd_data = '0;
  logic        vsync;
  logic        href;
  logic [7:0]  D;
  logic        frame_done;
  logic        busy;

  logic [11:0] mem [0:NPIX-1];

  logic [7:0] spec_d [0:15] = '{
    8'h00, 8'h00, 8'h01, 8'h11,
    8'h02, 8'h22, 8'h03, 8'h33,
    8'h04, 8'h44, 8'h05, 8'h55,
    8'h06, 8'h66, 8'h07, 8'h77
  };

  logic        cap_vs [0:FRAME];
  logic        cap_hr [0:FRAME];
  logic [7:0]  cap_d  [0:FRAME];
  logic        cap_re [0:FRAME];
  logic [18:0] cap_ad [0:FRAME];
  logic        cap_fd [0:FRAME];
  logic        cap_bz [0:FRAME];

  int compared   = 0;
  int mismatched = 0;

  cam_tx #(
    .H_ACTIVE (HA),
    .V_ACTIVE (VA),
    .H_BLANK  (HB),
    .VSYNC_CYC(VS),
    .VBP_CYC  (VBP),
    .VFP_CYC  (VFP)
  ) dut (
    .pclk      (pclk),
    .rst       (rst),
    .en        (en),
    .rd_addr   (rd_addr),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .vsync     (vsync),
    .href      (href),
    .D         (D),
    .frame_done(frame_done),
    .busy      (busy)
  );

  always #5 pclk = ~pclk;

  // Frame buffer with one cycle of read latency.
  always @(posedge pclk)
    if (rd_en) rd_data <= mem[rd_addr[2:0]];

  // Byte index within the frame for cycle c from the vsync
  // rise, or -1 when href is expected low.
  function automatic int byte_idx(int c);
    int f;
    int r;
    f = c % FRAME;
    if (f < VS + VBP) return -1;
    r = f - VS - VBP;
    if (r / LINE >= VA) return -1;
    if (r % LINE >= 2 * HA) return -1;
    return (r / LINE) * 2 * HA + r % LINE;
  endfunction

  function automatic logic exp_vs(int c);
    return (c % FRAME) < VS;
  endfunction

  function automatic logic [7:0] exp_d(int c);
    int b;
    b = byte_idx(c);
    if (b < 0) return 8'h00;
    if (b % 2 == 0) return {4'h0, mem[b/2][11:8]};
    return mem[b/2][7:0];
  endfunction

  task automatic sample(int i);
    cap_vs[i] = vsync;
    cap_hr[i] = href;
    cap_d[i]  = D;
    cap_re[i] = rd_en;
    cap_ad[i] = rd_addr;
    cap_fd[i] = frame_done;
    cap_bz[i] = busy;
  endtask

  // Records cycles 0..FRAME starting at the current
  // negedge; ends on the next frame's vsync rise cycle.
  task automatic capture();
    for (int i = 0; i <= FRAME; i++) begin
      if (i > 0) @(negedge pclk);
      sample(i);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en  = 1'b0;
    repeat (3) @(negedge pclk);
    compared++;
    if ({vsync, href, D, rd_en, rd_addr,
         frame_done, busy} !== '0) begin
      mismatched++;
      $display("FAIL reset_outputs: vs=%b hr=%b D=%h re=%b a=%0d fd=%b bz=%b, want all 0",
               vsync, href, D, rd_en, rd_addr,
               frame_done, busy);
    end
    en = 1'b1;
    repeat (2) @(negedge pclk);
    compared++;
    if ({vsync, busy} !== 2'b00) begin
      mismatched++;
      $display("FAIL reset_priority: vs=%b busy=%b, want 0 0",
               vsync, busy);
    end
  endtask

  task automatic test_frame();
    int n;
    int b;
    logic [18:0] amax;
    logic [7:0] want;
    for (int i = 0; i < NPIX; i++)
      mem[i] = 12'(i * 'h111);
    rst = 1'b0;
    @(negedge pclk);
    compared++;
    if (vsync !== 1'b0) begin
      mismatched++;
      $display("FAIL start_edge1: vsync=%b want 0", vsync);
    end
    @(negedge pclk);
    compared++;
    if (vsync !== 1'b1) begin
      mismatched++;
      $display("FAIL start_edge2: vsync=%b want 1", vsync);
    end
    capture();
    for (int c = 0; c <= FRAME; c++) begin
      b = byte_idx(c);
      want = (b < 0) ? 8'h00 : spec_d[b];
      compared++;
      if (cap_vs[c] !== exp_vs(c)) begin
        mismatched++;
        $display("FAIL vsync c=%0d: got %b want %b",
                 c, cap_vs[c], exp_vs(c));
      end
      compared++;
      if (cap_hr[c] !== (b >= 0)) begin
        mismatched++;
        $display("FAIL href c=%0d: got %b want %b",
                 c, cap_hr[c], b >= 0);
      end
      compared++;
      if (cap_d[c] !== want) begin
        mismatched++;
        $display("FAIL D c=%0d: got %h want %h",
                 c, cap_d[c], want);
      end
    end
    n = 0;
    amax = '0;
    for (int c = 0; c <= FRAME; c++) begin
      if (cap_ad[c] > amax) amax = cap_ad[c];
      if (cap_re[c] === 1'b1) begin
        compared++;
        if (cap_ad[c] !== 19'(n)) begin
          mismatched++;
          $display("FAIL rd_addr_seq c=%0d: got %0d want %0d",
                   c, cap_ad[c], n);
        end
        compared++;
        if (c + 3 > FRAME || n >= NPIX) begin
          mismatched++;
          $display("FAIL rd_latency c=%0d: read %0d outside frame window",
                   c, n);
        end else if (cap_d[c+2] !== {4'h0, mem[n][11:8]} ||
                     cap_d[c+3] !== mem[n][7:0]) begin
          mismatched++;
          $display("FAIL rd_latency c=%0d: got %h %h want %h %h",
                   c, cap_d[c+2], cap_d[c+3],
                   {4'h0, mem[n][11:8]}, mem[n][7:0]);
        end
        n++;
      end
    end
    compared++;
    if (n != NPIX) begin
      mismatched++;
      $display("FAIL rd_en_count: got %0d want %0d", n, NPIX);
    end
    compared++;
    if (amax > 19'(NPIX - 1)) begin
      mismatched++;
      $display("FAIL rd_addr_max: got %0d want <= %0d",
               amax, NPIX - 1);
    end
    for (int l = 0; l < VA; l++) begin
      b = VS + VBP + l * LINE;
      compared++;
      if (cap_re[b-2] !== 1'b1 && cap_re[b-1] !== 1'b1) begin
        mismatched++;
        $display("FAIL line_prefetch l=%0d: got %b%b want a strobe",
                 l, cap_re[b-2], cap_re[b-1]);
      end
    end
    n = 0;
    b = 0;
    for (int c = 1; c < FRAME; c++) begin
      if (cap_fd[c] === 1'b1) n++;
      if (cap_bz[c] !== 1'b1) b++;
    end
    compared++;
    if (n != 0 || cap_fd[FRAME] !== 1'b1) begin
      mismatched++;
      $display("FAIL frame_done: early=%0d end=%b want 0 1",
               n, cap_fd[FRAME]);
    end
    compared++;
    if (b != 0) begin
      mismatched++;
      $display("FAIL busy_frame: low cycles=%0d want 0", b);
    end
  endtask

  task automatic test_back_to_back();
    int errs;
    int n;
    logic [18:0] first;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < NPIX; i++)
        mem[i] = 12'($urandom);
      capture();
      errs = 0;
      n = 0;
      first = '1;
      for (int c = 0; c <= FRAME; c++) begin
        if (cap_d[c] !== exp_d(c)) errs++;
        if (cap_hr[c] !== (byte_idx(c) >= 0)) errs++;
        if (cap_vs[c] !== exp_vs(c)) errs++;
        if (cap_re[c] === 1'b1) begin
          if (n == 0) first = cap_ad[c];
          n++;
        end
      end
      compared++;
      if (errs != 0) begin
        mismatched++;
        $display("FAIL b2b_stream f=%0d: bad cycles=%0d want 0",
                 f, errs);
      end
      compared++;
      if (n != NPIX || first !== '0) begin
        mismatched++;
        $display("FAIL b2b_reads f=%0d: got %0d from %0d want %0d from 0",
                 f, n, first, NPIX);
      end
      compared++;
      if (cap_fd[FRAME] !== 1'b1) begin
        mismatched++;
        $display("FAIL b2b_done f=%0d: got %b want 1",
                 f, cap_fd[FRAME]);
      end
    end
  endtask

  task automatic test_en_drop();
    int fds;
    int hrs;
    int vs_after;
    int bz_after;
    logic bz_last;
    logic bz_end;
    logic fd_end;
    fds = 0;
    hrs = 0;
    vs_after = 0;
    bz_after = 0;
    bz_last = 1'b0;
    bz_end = 1'b1;
    fd_end = 1'b0;
    for (int c = 0; c <= FRAME + 40; c++) begin
      if (c > 0) begin
        @(negedge pclk);
        if (frame_done === 1'b1) fds++;
      end
      if (href === 1'b1) hrs++;
      if (c == FRAME - 1) bz_last = busy;
      if (c == FRAME) begin
        bz_end = busy;
        fd_end = frame_done;
      end
      if (c >= FRAME && vsync !== 1'b0) vs_after++;
      if (c > FRAME && busy !== 1'b0) bz_after++;
      if (c == 10) en = 1'b0;
    end
    compared++;
    if (hrs != VA * 2 * HA) begin
      mismatched++;
      $display("FAIL drop_href: got %0d want %0d",
               hrs, VA * 2 * HA);
    end
    compared++;
    if (fds != 1 || fd_end !== 1'b1) begin
      mismatched++;
      $display("FAIL drop_done: pulses=%0d end=%b want 1 1",
               fds, fd_end);
    end
    compared++;
    if (bz_last !== 1'b1 || bz_end !== 1'b0 ||
        bz_after != 0) begin
      mismatched++;
      $display("FAIL drop_busy: last=%b end=%b after=%0d want 1 0 0",
               bz_last, bz_end, bz_after);
    end
    compared++;
    if (vs_after != 0) begin
      mismatched++;
      $display("FAIL drop_vsync: high cycles=%0d want 0",
               vs_after);
    end
  endtask

  task automatic test_en_rejoin();
    int waited;
    int fds;
    int lows;
    en = 1'b1;
    waited = 0;
    while (vsync !== 1'b1 && waited < 10) begin
      @(negedge pclk);
      waited++;
    end
    compared++;
    if (vsync !== 1'b1) begin
      mismatched++;
      $display("FAIL rejoin_start: vsync=%b after %0d cycles want 1",
               vsync, waited);
    end
    fds = 0;
    lows = 0;
    for (int c = 1; c <= FRAME; c++) begin
      @(negedge pclk);
      if (c < FRAME && frame_done === 1'b1) fds++;
      if (busy !== 1'b1) lows++;
      if (c == 10) en = 1'b0;
      if (c == FRAME - 2) en = 1'b1;
    end
    compared++;
    if (vsync !== 1'b1 || frame_done !== 1'b1) begin
      mismatched++;
      $display("FAIL rejoin_wrap: vs=%b fd=%b want 1 1",
               vsync, frame_done);
    end
    compared++;
    if (lows != 0 || fds != 0) begin
      mismatched++;
      $display("FAIL rejoin_idle: busy low=%0d early fd=%0d want 0 0",
               lows, fds);
    end
  endtask

  task automatic test_rst_mid();
    int errs;
    int n;
    logic [18:0] first;
    for (int c = 1; c <= 22; c++) @(negedge pclk);
    rst = 1'b1;
    @(negedge pclk);
    compared++;
    if ({vsync, href, D, rd_en, rd_addr,
         frame_done, busy} !== '0) begin
      mismatched++;
      $display("FAIL rst_mid: vs=%b hr=%b D=%h re=%b a=%0d fd=%b bz=%b, want all 0",
               vsync, href, D, rd_en, rd_addr,
               frame_done, busy);
    end
    @(negedge pclk);
    compared++;
    if (frame_done !== 1'b0) begin
      mismatched++;
      $display("FAIL rst_mid_done: got %b want 0",
               frame_done);
    end
    rst = 1'b0;
    @(negedge pclk);
    compared++;
    if (vsync !== 1'b0) begin
      mismatched++;
      $display("FAIL restart_edge1: vsync=%b want 0", vsync);
    end
    @(negedge pclk);
    compared++;
    if (vsync !== 1'b1) begin
      mismatched++;
      $display("FAIL restart_edge2: vsync=%b want 1", vsync);
    end
    capture();
    errs = 0;
    n = 0;
    first = '1;
    for (int c = 0; c <= FRAME; c++) begin
      if (cap_d[c] !== exp_d(c)) errs++;
      if (cap_re[c] === 1'b1) begin
        if (n == 0) first = cap_ad[c];
        n++;
      end
    end
    compared++;
    if (errs != 0) begin
      mismatched++;
      $display("FAIL restart_stream: bad cycles=%0d want 0",
               errs);
    end
    compared++;
    if (n != NPIX || first !== '0) begin
      mismatched++;
      $display("FAIL restart_reads: got %0d from %0d want %0d from 0",
               n, first, NPIX);
    end
  endtask

  initial begin
    for (int i = 0; i < NPIX; i++) mem[i] = '0;
    @(negedge pclk);
    test_reset();
    test_frame();
    test_back_to_back();
    test_en_drop();
    test_en_rejoin();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
